vin_bus_sequencer: RTL and testbench
====================================

VIN_BUS_SEQUENCER -- requirements
Module: vin_bus_sequencer

Interface
REQ-001 Parameter COLS, default 40, character cells fetched per row slice.
REQ-002 Parameter MEM_AW, default 10, VRAM word-address width.
REQ-003 clk  input  1  system clock, nominal 14 MHz; single clock domain.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 line_start  input  1  one-clock pulse; begins fetch of one row slice.
REQ-006 line_base  input  MEM_AW  VRAM address of cell 0, sampled on line_start.
REQ-007 slice  input  4  character row slice 0..9, sampled on line_start.
REQ-008 ve_n  input  1  generator busy flag, low = mailbox cycle pending.
REQ-009 mb_rd  input  1  mailbox direction, sampled with ve_n: 1 = VRAM->mailbox, 0 = mailbox->VRAM.
REQ-010 mb_addr  input  MEM_AW  VRAM address for the mailbox cycle.
REQ-011 sm_n, st_n, sg_n  output  1 each  generator bus strobes, active low.
REQ-012 r_wi  output  1  internal bus direction, 1 = generator reads bus.
REQ-013 adr  output  4  slice index presented to generator.
REQ-014 mem_addr  output  MEM_AW  VRAM address; mem_we  output  1  VRAM write strobe.
REQ-015 pix_load  output  1  one-clock pulse, generator pattern valid on busA.
REQ-016 line_done  output  1  one-clock pulse after last cell; overrun  output  1  sticky flag.

Function
REQ-017 Every bus cycle SHALL last 4 clocks: T0 address/r_wi set, strobes high; T1-T2 strobe low; T3 strobes high, hold.
REQ-018 States SHALL be IDLE, FETCH_CODE, FETCH_PAT, MB_READ, MB_WRITE.
REQ-019 FETCH_CODE (type 1): r_wi=1, st_n=1, sm_n low T1-T2, mem_addr=base+col.
REQ-020 FETCH_PAT (type 2): r_wi=1, st_n=1, sg_n low T1-T2, adr=slice; pix_load high in T3.
REQ-021 Each cell SHALL be FETCH_CODE then FETCH_PAT: 8 clocks/cell, 8*COLS clocks/slice.
REQ-022 col SHALL count 0..COLS-1; after col=COLS-1 FETCH_PAT, line_done pulses and state returns to IDLE; col resets to 0.
REQ-023 mem_addr arithmetic SHALL be modulo 2^MEM_AW (base+col wraps).
REQ-024 MB_READ (type 4): r_wi=1, st_n and sm_n low T1-T2, mem_addr=mb_addr.
REQ-025 MB_WRITE (type 3): r_wi=0, st_n low T1-T2, mem_we high T2 only, mem_addr=mb_addr.
REQ-026 From IDLE: pending line_start wins over ve_n low; ve_n low with no line pending enters MB_READ/MB_WRITE per mb_rd.
REQ-027 Mailbox cycles SHALL NOT occur while a slice is in progress; ve_n low is serviced at the first IDLE.
REQ-028 line_start during a mailbox cycle SHALL be latched as pending and begun at that cycle's T3+1 clock.
REQ-029 line_start while a slice is in progress or already pending SHALL be dropped and set overrun; overrun clears only on rst.
REQ-030 One mailbox cycle per ve_n sample; ve_n still low after return to IDLE triggers another cycle.
REQ-031 line_start and ve_n low in the same IDLE clock: slice starts, mailbox deferred.

Reset
REQ-032 On rst: sm_n=st_n=sg_n=1, r_wi=1, adr=0, mem_addr=0, mem_we=0, pix_load=0, line_done=0, overrun=0, state IDLE, col=0, pending cleared.
REQ-033 rst asserted mid-cycle SHALL deassert all strobes immediately (asynchronous); no partial cycle resumes after release.
REQ-034 First line_start honoured one clock after rst deassertion.

Structure
REQ-035 Shared package vin_seq_pkg SHALL hold state enum, phase encoding T0..T3, CYCLE_LEN=4.
REQ-036 One sub-module vin_cycle_timer SHALL generate T0..T3 phase and end-of-cycle pulse; the FSM lives in vin_bus_sequencer.
REQ-037 All outputs SHALL be registered.

Verification
REQ-038 rst release, line_start, base=0x100, slice=3, COLS=40 -> 40 sm_n/sg_n pairs, adr=3, mem_addr 0x100..0x127, 40 pix_load, line_done at clock 320.
REQ-039 IDLE, ve_n=0, mb_rd=0, mb_addr=0x2A5 -> one type 3 cycle, r_wi=0, st_n low 2 clocks, mem_we one clock at 0x2A5.
REQ-040 ve_n=0, mb_rd=1, line_start in T1 of that cycle -> type 4 completes, slice starts next clock, overrun=0.
REQ-041 Second line_start at clock 100 of a slice -> ignored, overrun=1, slice still ends at clock 320.
REQ-042 base=0x3F0, MEM_AW=10 -> mem_addr wraps 0x3FF->0x000 at col 16.
REQ-043 rst asserted at col 12, T2 of FETCH_PAT -> strobes high same clock, no pix_load, IDLE after release.

Source files
------------

// File: rtl/vin_seq_pkg.sv
// Shared types for the VIN generator bus sequencer: FSM states, bus-cycle
// phases and the registered strobe bundle.
package vin_seq_pkg;

    localparam int CYCLE_LEN = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_CODE,
        FETCH_PAT,
        MB_READ,
        MB_WRITE
    } seq_state_e;

    typedef enum logic [1:0] {
        T0,
        T1,
        T2,
        T3
    } phase_e;

    localparam phase_e LAST_PHASE = phase_e'(2'(CYCLE_LEN - 1));

    typedef struct packed {
        logic sm_n;
        logic st_n;
        logic sg_n;
        logic r_wi;
        logic mem_we;
        logic pix_load;
        logic line_done;
    } bus_ctrl_t;

    localparam bus_ctrl_t CTRL_IDLE = '{
        sm_n:      1'b1,
        st_n:      1'b1,
        sg_n:      1'b1,
        r_wi:      1'b1,
        mem_we:    1'b0,
        pix_load:  1'b0,
        line_done: 1'b0
    };

    // Strobes are driven low only in the two middle phases of a cycle.
    function automatic logic strobe_phase(input phase_e ph);
        return (ph == T1) || (ph == T2);
    endfunction

endpackage

// File: rtl/vin_cycle_timer.sv
// Phase counter for one generator bus cycle: T0..T3 while running, parked at
// T0 when idle, with an end-of-cycle flag during T3.
module vin_cycle_timer
    import vin_seq_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   run_i,
    output phase_e phase_o,
    output logic   cycle_end_o
);

    phase_e phase_q;
    phase_e phase_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        phase_d = T0;
        if (run_i && (phase_q != LAST_PHASE)) begin
            phase_d = phase_e'(phase_q + 2'd1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q <= T0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o     = phase_q;
    assign cycle_end_o = run_i && (phase_q == LAST_PHASE);

endmodule

// File: rtl/vin_bus_sequencer.sv
// Generator bus sequencer: fetches code/pattern pairs for one character row
// slice and interleaves mailbox VRAM cycles between slices.
module vin_bus_sequencer
    import vin_seq_pkg::*;
#(
    parameter int COLS   = 40,
    parameter int MEM_AW = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [MEM_AW-1:0] line_base,
    input  logic [3:0]        slice,
    input  logic              ve_n,
    input  logic              mb_rd,
    input  logic [MEM_AW-1:0] mb_addr,
    output logic              sm_n,
    output logic              st_n,
    output logic              sg_n,
    output logic              r_wi,
    output logic [3:0]        adr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic              pix_load,
    output logic              line_done,
    output logic              overrun
);

    localparam int            CW       = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     col_q, col_d;
    logic [MEM_AW-1:0] base_q, base_d;
    logic [MEM_AW-1:0] mb_addr_q, mb_addr_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        slice_q, slice_d;
    logic [3:0]        adr_q, adr_d;
    logic              pend_q, pend_d;
    logic              overrun_q, ovr_set;
    bus_ctrl_t         ctrl_q, ctrl_d;
    phase_e            phase;
    logic              cycle_end;
    logic              mid;
    logic              last_col;

    vin_cycle_timer u_timer (
        .clk         (clk),
        .rst         (rst),
        .run_i       (state_q != IDLE),
        .phase_o     (phase),
        .cycle_end_o (cycle_end)
    );

    assign mid      = strobe_phase(phase);
    assign last_col = (col_q == COL_LAST);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        base_d    = base_q;
        slice_d   = slice_q;
        mb_addr_d = mb_addr_q;
        pend_d    = pend_q;
        ovr_set   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // A waiting slice always beats a mailbox request.
                if (line_start) begin
                    state_d = FETCH_CODE;
                    base_d  = line_base;
                    slice_d = slice;
                    col_d   = '0;
                end else if (!ve_n) begin
                    state_d   = mb_rd ? MB_READ : MB_WRITE;
                    mb_addr_d = mb_addr;
                end
            end
            FETCH_CODE: begin
                ovr_set = line_start;
                if (cycle_end) begin
                    state_d = FETCH_PAT;
                end
            end
            FETCH_PAT: begin
                ovr_set = line_start;
                if (cycle_end) begin
                    if (last_col) begin
                        col_d   = '0;
                        state_d = IDLE;
                    end else begin
                        col_d   = col_q + CW'(1);
                        state_d = FETCH_CODE;
                    end
                end
            end
            MB_READ, MB_WRITE: begin
                if (line_start) begin
                    if (pend_q) begin
                        ovr_set = 1'b1;
                    end else begin
                        pend_d  = 1'b1;
                        base_d  = line_base;
                        slice_d = slice;
                    end
                end
                // A slice requested during the mailbox cycle starts right after T3.
                if (cycle_end) begin
                    state_d = (pend_q || line_start) ? FETCH_CODE : IDLE;
                    pend_d  = 1'b0;
                    col_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ctrl_d     = CTRL_IDLE;
        mem_addr_d = mem_addr_q;
        adr_d      = adr_q;
        unique case (state_q)
            FETCH_CODE: begin
                ctrl_d.sm_n = !mid;
                mem_addr_d  = base_q + MEM_AW'(col_q);
            end
            FETCH_PAT: begin
                ctrl_d.sg_n      = !mid;
                ctrl_d.pix_load  = (phase == LAST_PHASE);
                ctrl_d.line_done = (phase == LAST_PHASE) && last_col;
                adr_d            = slice_q;
            end
            MB_READ: begin
                ctrl_d.sm_n = !mid;
                ctrl_d.st_n = !mid;
                mem_addr_d  = mb_addr_q;
            end
            MB_WRITE: begin
                ctrl_d.r_wi   = 1'b0;
                ctrl_d.st_n   = !mid;
                ctrl_d.mem_we = (phase == T2);
                mem_addr_d    = mb_addr_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            col_q      <= '0;
            base_q     <= '0;
            slice_q    <= '0;
            mb_addr_q  <= '0;
            pend_q     <= 1'b0;
            ctrl_q     <= CTRL_IDLE;
            mem_addr_q <= '0;
            adr_q      <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            base_q     <= base_d;
            slice_q    <= slice_d;
            mb_addr_q  <= mb_addr_d;
            pend_q     <= pend_d;
            ctrl_q     <= ctrl_d;
            mem_addr_q <= mem_addr_d;
            adr_q      <= adr_d;
            overrun_q  <= overrun_q | ovr_set;
        end
    end

    assign sm_n      = ctrl_q.sm_n;
    assign st_n      = ctrl_q.st_n;
    assign sg_n      = ctrl_q.sg_n;
    assign r_wi      = ctrl_q.r_wi;
    assign mem_we    = ctrl_q.mem_we;
    assign pix_load  = ctrl_q.pix_load;
    assign line_done = ctrl_q.line_done;
    assign adr       = adr_q;
    assign mem_addr  = mem_addr_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_vin_bus_sequencer.sv
// Self-checking bench for vin_bus_sequencer: records every output per clock
// and compares against an expected waveform built from bus-cycle rules.
module tb_vin_bus_sequencer;

    localparam int COLS   = 40;
    localparam int MEM_AW = 10;
    localparam int MAXN   = 400;

    localparam int B_SM   = 7;
    localparam int B_SG   = 6;
    localparam int B_ST   = 5;
    localparam int B_RWI  = 4;
    localparam int B_WE   = 3;
    localparam int B_PIX  = 2;
    localparam int B_DONE = 1;
    localparam int B_OVR  = 0;

    localparam int K_CODE = 0;
    localparam int K_PAT  = 1;
    localparam int K_MBR  = 2;
    localparam int K_MBW  = 3;

    logic              clk        = 1'b0;
    logic              rst        = 1'b1;
    logic              line_start = 1'b0;
    logic [MEM_AW-1:0] line_base  = '0;
    logic [3:0]        slice      = '0;
    logic              ve_n       = 1'b1;
    logic              mb_rd      = 1'b0;
    logic [MEM_AW-1:0] mb_addr    = '0;
    logic              sm_n, st_n, sg_n, r_wi, mem_we, pix_load, line_done, overrun;
    logic [3:0]        adr;
    logic [MEM_AW-1:0] mem_addr;

    int checks = 0;
    int errors = 0;
    int cnt;

    logic [7:0]        obs_vec  [0:MAXN];
    logic [7:0]        exp_vec  [0:MAXN];
    logic [MEM_AW-1:0] obs_addr [0:MAXN];
    logic [MEM_AW-1:0] exp_addr [0:MAXN];
    logic              addr_ok  [0:MAXN];
    logic [3:0]        obs_adr  [0:MAXN];
    logic [3:0]        exp_adr  [0:MAXN];
    logic              adr_ok   [0:MAXN];
    logic              ovr_model = 1'b0;

    logic [MEM_AW-1:0] b1, b2;
    logic [3:0]        s1;
    logic              r1, r2;

    vin_bus_sequencer #(.COLS(COLS), .MEM_AW(MEM_AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .line_start (line_start),
        .line_base  (line_base),
        .slice      (slice),
        .ve_n       (ve_n),
        .mb_rd      (mb_rd),
        .mb_addr    (mb_addr),
        .sm_n       (sm_n),
        .st_n       (st_n),
        .sg_n       (sg_n),
        .r_wi       (r_wi),
        .adr        (adr),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .pix_load   (pix_load),
        .line_done  (line_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic record(input int i);
        obs_vec[i]  = {sm_n, sg_n, st_n, r_wi, mem_we, pix_load, line_done, overrun};
        obs_addr[i] = mem_addr;
        obs_adr[i]  = adr;
    endtask

    task automatic check_reset(input string tag);
        check(tag, 32'({sm_n, st_n, sg_n, r_wi, adr, mem_addr, mem_we, pix_load, line_done, overrun}),
              32'({4'b1111, 4'd0, 10'd0, 4'b0000}));
    endtask

    // Expected waveform: bus idle everywhere, overrun at its modelled level.
    task automatic exp_idle(input int n);
        for (int i = 0; i <= n; i++) begin
            exp_vec[i] = {7'b1111000, ovr_model};
            addr_ok[i] = 1'b0;
            adr_ok[i]  = 1'b0;
        end
    endtask

    // One 4-clock bus cycle whose state begins at edge s; outputs show it at s+1..s+4.
    task automatic exp_bus(input int s, input int kind, input logic [MEM_AW-1:0] a, input logic [3:0] sl);
        for (int t = 1; t <= 4; t++) begin
            int   o;
            logic md;
            o  = s + t;
            md = (t == 2) || (t == 3);
            case (kind)
                K_CODE: begin
                    if (md) exp_vec[o][B_SM] = 1'b0;
                    exp_addr[o] = a;
                    addr_ok[o]  = 1'b1;
                end
                K_PAT: begin
                    if (md) exp_vec[o][B_SG] = 1'b0;
                    if (t == 4) exp_vec[o][B_PIX] = 1'b1;
                    exp_adr[o] = sl;
                    adr_ok[o]  = 1'b1;
                end
                K_MBR: begin
                    if (md) begin
                        exp_vec[o][B_SM] = 1'b0;
                        exp_vec[o][B_ST] = 1'b0;
                    end
                    exp_addr[o] = a;
                    addr_ok[o]  = 1'b1;
                end
                default: begin
                    exp_vec[o][B_RWI] = 1'b0;
                    if (md) exp_vec[o][B_ST] = 1'b0;
                    if (t == 3) exp_vec[o][B_WE] = 1'b1;
                    exp_addr[o] = a;
                    addr_ok[o]  = 1'b1;
                end
            endcase
        end
    endtask

    task automatic exp_slice(input int s, input logic [MEM_AW-1:0] base, input logic [3:0] sl);
        for (int k = 0; k < COLS; k++) begin
            exp_bus(s + 8 * k, K_CODE, MEM_AW'((int'(base) + k) % (1 << MEM_AW)), sl);
            exp_bus(s + 8 * k + 4, K_PAT, '0, sl);
        end
        exp_vec[s + 8 * COLS][B_DONE] = 1'b1;
    endtask

    task automatic compare_obs(input string tag, input int n);
        int f;
        int fv;
        f = -1;
        for (int i = 0; i <= n; i++) if (f < 0 && obs_vec[i] !== exp_vec[i]) f = i;
        if (f < 0) f = n;
        check($sformatf("%s ctrl@%0d", tag, f), 32'(obs_vec[f]), 32'(exp_vec[f]));
        f = -1; fv = -1;
        for (int i = 0; i <= n; i++) begin
            if (addr_ok[i]) begin
                if (fv < 0) fv = i;
                if (f < 0 && obs_addr[i] !== exp_addr[i]) f = i;
            end
        end
        if (f < 0) f = fv;
        if (f >= 0) check($sformatf("%s mem_addr@%0d", tag, f), 32'(obs_addr[f]), 32'(exp_addr[f]));
        f = -1; fv = -1;
        for (int i = 0; i <= n; i++) begin
            if (adr_ok[i]) begin
                if (fv < 0) fv = i;
                if (f < 0 && obs_adr[i] !== exp_adr[i]) f = i;
            end
        end
        if (f < 0) f = fv;
        if (f >= 0) check($sformatf("%s adr@%0d", tag, f), 32'(obs_adr[f]), 32'(exp_adr[f]));
    endtask

    initial begin
        repeat (3) step();
        check_reset("reset_state");

        // Slice right after reset release: base 0x100, slice 3.
        line_base  = 10'h100;
        slice      = 4'd3;
        line_start = 1'b1;
        rst        = 1'b0;
        exp_idle(330);
        exp_slice(0, 10'h100, 4'd3);
        for (int i = 0; i <= 330; i++) begin
            step(); record(i);
            if (i == 0) line_start = 1'b0;
        end
        compare_obs("slice_100", 330);
        check("slice_done_at_320", 32'(obs_vec[320][B_DONE]), 32'd1);
        cnt = 0;
        for (int i = 0; i <= 330; i++) if (obs_vec[i][B_PIX]) cnt++;
        check("slice_pix_count", 32'(cnt), 32'(COLS));

        // Mailbox write to 0x2A5.
        ve_n = 1'b0; mb_rd = 1'b0; mb_addr = 10'h2A5;
        exp_idle(8);
        exp_bus(0, K_MBW, 10'h2A5, '0);
        for (int i = 0; i <= 8; i++) begin
            step(); record(i);
            if (i == 0) ve_n = 1'b1;
        end
        compare_obs("mb_write", 8);
        cnt = 0;
        for (int i = 0; i <= 8; i++) if (obs_vec[i][B_WE]) cnt++;
        check("mb_write_we_pulses", 32'(cnt), 32'd1);

        // ve_n held low: one cycle per IDLE sample, random directions/addresses.
        r1 = 1'($urandom_range(1, 0)); r2 = 1'($urandom_range(1, 0));
        b1 = MEM_AW'($urandom);        b2 = MEM_AW'($urandom);
        ve_n = 1'b0; mb_rd = r1; mb_addr = b1;
        exp_idle(12);
        exp_bus(0, r1 ? K_MBR : K_MBW, b1, '0);
        exp_bus(5, r2 ? K_MBR : K_MBW, b2, '0);
        for (int i = 0; i <= 12; i++) begin
            step(); record(i);
            if (i == 0) begin mb_rd = r2; mb_addr = b2; end
            if (i == 5) ve_n = 1'b1;
        end
        compare_obs("mb_repeat", 12);

        // Mailbox read with line_start arriving in T1: slice follows at T3+1.
        b1 = MEM_AW'($urandom); b2 = MEM_AW'($urandom); s1 = 4'($urandom_range(9, 0));
        ve_n = 1'b0; mb_rd = 1'b1; mb_addr = b1;
        exp_idle(330);
        exp_bus(0, K_MBR, b1, '0);
        exp_slice(4, b2, s1);
        for (int i = 0; i <= 330; i++) begin
            step(); record(i);
            if (i == 0) ve_n = 1'b1;
            if (i == 1) begin line_start = 1'b1; line_base = b2; slice = s1; end
            if (i == 2) begin line_start = 1'b0; line_base = ~b2; slice = 4'd9 - s1; end
        end
        compare_obs("mb_then_slice", 330);
        check("mb_then_slice_overrun", 32'(overrun), 32'd0);

        // Address wrap: base 0x3F0 wraps 0x3FF -> 0x000 at col 16.
        s1 = 4'($urandom_range(9, 0));
        line_start = 1'b1; line_base = 10'h3F0; slice = s1;
        exp_idle(330);
        exp_slice(0, 10'h3F0, s1);
        for (int i = 0; i <= 330; i++) begin
            step(); record(i);
            if (i == 0) line_start = 1'b0;
        end
        compare_obs("wrap", 330);
        check("wrap_col15", 32'(obs_addr[121]), 32'h3FF);
        check("wrap_col16", 32'(obs_addr[129]), 32'h000);

        // line_start and ve_n low together: slice first, mailbox deferred to next IDLE.
        b1 = MEM_AW'($urandom); b2 = MEM_AW'($urandom);
        s1 = 4'($urandom_range(9, 0)); r1 = 1'($urandom_range(1, 0));
        line_start = 1'b1; line_base = b1; slice = s1;
        ve_n = 1'b0; mb_rd = r1; mb_addr = b2;
        exp_idle(330);
        exp_slice(0, b1, s1);
        exp_bus(321, r1 ? K_MBR : K_MBW, b2, '0);
        for (int i = 0; i <= 330; i++) begin
            step(); record(i);
            if (i == 0) line_start = 1'b0;
            if (i == 321) ve_n = 1'b1;
        end
        compare_obs("slice_defers_mb", 330);

        // Second line_start at clock 100 is dropped and sets the sticky overrun.
        b1 = MEM_AW'($urandom); b2 = ~b1; s1 = 4'($urandom_range(9, 0));
        line_start = 1'b1; line_base = b1; slice = s1;
        exp_idle(330);
        exp_slice(0, b1, s1);
        for (int i = 100; i <= 330; i++) exp_vec[i][B_OVR] = 1'b1;
        ovr_model = 1'b1;
        for (int i = 0; i <= 330; i++) begin
            step(); record(i);
            if (i == 0) line_start = 1'b0;
            if (i == 99) begin line_start = 1'b1; line_base = b2; slice = 4'd9 - s1; end
            if (i == 100) line_start = 1'b0;
        end
        compare_obs("overrun_slice", 330);
        check("overrun_sticky", 32'(overrun), 32'd1);

        // Reset at col 12, T2 of FETCH_PAT: strobes release at once, bus idle afterwards.
        b1 = MEM_AW'($urandom); s1 = 4'($urandom_range(9, 0));
        line_start = 1'b1; line_base = b1; slice = s1;
        exp_idle(103);
        exp_slice(0, b1, s1);
        for (int i = 0; i <= 103; i++) begin
            step(); record(i);
            if (i == 0) line_start = 1'b0;
        end
        compare_obs("pre_reset", 103);
        check("pre_reset_sg_low", 32'(obs_vec[103][B_SG]), 32'd0);
        rst = 1'b1;
        #1;
        check_reset("async_reset_midcycle");
        step();
        step();
        check_reset("reset_held");
        rst = 1'b0;
        ovr_model = 1'b0;
        exp_idle(12);
        for (int i = 0; i <= 12; i++) begin
            step(); record(i);
        end
        compare_obs("idle_after_reset", 12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
